// File: rtl/k12a_rom_ctrl.sv
// -----------------------------------------------------------------------------
// k12a_rom_ctrl
// Read sequencer and two-port arbiter for a 28256 (32 KiB) asynchronous EEPROM.
// Fetch and data requesters are granted one at a time. Each access runs
// IDLE -> SETUP -> READ (WAIT_CYCLES+1 cycles) -> RECOVER. The byte is sampled
// on the last READ cycle and is returned with a one-cycle ack in RECOVER.
// The ROM data bus is input-only here and is never driven.
//
// Build option:
//   K12A_ROM_CTRL_ROUND_ROBIN_EN  defined   : round-robin between fetch/data
//                                 undefined : fixed priority, fetch wins
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   fetch_req   in   fetch read request (level, held until fetch_ack)
//   fetch_addr  in   fetch byte address [14:0]
//   fetch_ack   out  one-cycle pulse, rdata valid for fetch
//   data_req    in   data read request (level, held until data_ack)
//   data_addr   in   data byte address [14:0]
//   data_ack    out  one-cycle pulse, rdata valid for data
//   rdata       out  last byte read [7:0], holds until next ack
//   busy        out  high whenever the sequencer is not idle
//   rom_addr    out  ROM address [14:0]
//   rom_data    in   ROM data bus [7:0]
//   rom_ce_n    out  ROM chip enable, active low
//   rom_oe_n    out  ROM output enable, active low
// -----------------------------------------------------------------------------
module k12a_rom_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [14:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic [14:0] data_addr,
  output logic        data_ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        rom_ce_n,
  output logic        rom_oe_n
);

  // state    | meaning
  // ---------+-------------------------------------------------------------
  // IDLE     | ROM deselected; arbitrate and latch address when a req is up
  // SETUP    | CE low, OE high; address settles; wait counter loaded
  // READ     | CE and OE low; counter runs down, byte sampled at zero
  // RECOVER  | ROM deselected; granted ack pulses with rdata valid
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_READ    = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;      // 0 = fetch, 1 = data
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        fetch_ack_q, fetch_ack_d;
  logic        data_ack_q, data_ack_d;
  logic        busy_q, busy_d;
  logic        rom_ce_n_q, rom_ce_n_d;
  logic        rom_oe_n_q, rom_oe_n_d;

  logic        req_any;
  logic        pick_data;
  logic        read_done;

  assign req_any   = fetch_req | data_req;
  assign read_done = (state_q == ST_READ) && (cnt_q == 4'd0);

`ifdef K12A_ROM_CTRL_ROUND_ROBIN_EN
  logic last_q, last_d;               // last grant: 0 = fetch, 1 = data

  // With both requesting, serve whichever port was not served last.
  assign pick_data = data_req & (~fetch_req | ~last_q);

  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && req_any) begin
      last_d = pick_data;
    end
  end

  // Pointer starts at data so the first contested grant goes to fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: fetch always wins a contested cycle.
  assign pick_data = data_req & ~fetch_req;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. Strobes are derived from state_d so that
  // every output comes straight from a flop and tracks the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    rom_addr_d  = rom_addr_q;
    rdata_d     = rdata_q;
    fetch_ack_d = 1'b0;
    data_ack_d  = 1'b0;

    if ((state_q == ST_IDLE) && req_any) begin
      grant_d    = pick_data;
      rom_addr_d = pick_data ? data_addr : fetch_addr;
    end

    if (state_q == ST_SETUP) begin
      cnt_d = WAIT_LD;
    end else if ((state_q == ST_READ) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (read_done) begin
      rdata_d     = rom_data;
      fetch_ack_d = ~grant_q;
      data_ack_d  = grant_q;
    end

    rom_ce_n_d = ~((state_d == ST_SETUP) || (state_d == ST_READ));
    rom_oe_n_d = (state_d != ST_READ);
    busy_d     = (state_d != ST_IDLE);
  end

  // CE/OE flops reset high asynchronously, so a reset mid-access deselects
  // the ROM at once rather than at the next edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 4'd0;
      grant_q     <= 1'b0;
      rom_addr_q  <= 15'd0;
      rdata_q     <= 8'd0;
      fetch_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      rom_ce_n_q  <= 1'b1;
      rom_oe_n_q  <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      rom_addr_q  <= rom_addr_d;
      rdata_q     <= rdata_d;
      fetch_ack_q <= fetch_ack_d;
      data_ack_q  <= data_ack_d;
      busy_q      <= busy_d;
      rom_ce_n_q  <= rom_ce_n_d;
      rom_oe_n_q  <= rom_oe_n_d;
    end
  end

  assign fetch_ack = fetch_ack_q;
  assign data_ack  = data_ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign rom_addr  = rom_addr_q;
  assign rom_ce_n  = rom_ce_n_q;
  assign rom_oe_n  = rom_oe_n_q;

endmodule

// File: doc/k12a_rom_ctrl.md
Name: k12a_rom_ctrl

Overview:
Read sequencer and two-port arbiter for the 28256 32 KiB asynchronous boot/program EEPROM. It accepts read requests from the instruction-fetch unit and the data (load) path, grants one at a time, and drives rom_addr/rom_ce_n/rom_oe_n with a parameterised number of access wait states. It samples the ROM data bus and returns the byte with a one-cycle ack. The controller never drives the ROM data bus.

Parameters:
WAIT_CYCLES, 2, extra READ-state cycles beyond the first; legal range 0..15; counter is 4 bits.

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
fetch_req  input  1  fetch read request, level; held until fetch_ack
fetch_addr  input  15  fetch byte address
fetch_ack  output  1  one-cycle pulse; rdata valid for fetch
data_req  input  1  data read request, level; held until data_ack
data_addr  input  15  data byte address
data_ack  output  1  one-cycle pulse; rdata valid for data
rdata  output  8  last byte read; holds until next ack
busy  output  1  high in any state other than IDLE
rom_addr  output  15  ROM address
rom_data  input  8  ROM data bus; read only, never driven here
rom_ce_n  output  1  ROM chip enable, active low
rom_oe_n  output  1  ROM output enable, active low

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rom_ce_n=1, rom_oe_n=1, rom_addr=0, fetch_ack=0, data_ack=0, rdata=0, busy=0, grant=fetch, last-grant pointer=data.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE:
    - rom_ce_n=1, rom_oe_n=1.
    - If any req is high, arbitrate, latch the granted address into rom_addr, record the grant, and go to SETUP.
  - SETUP (1 cycle):
    - rom_ce_n=0, rom_oe_n=1, rom_addr stable.
    - Load counter=WAIT_CYCLES; go to READ.
  - READ (WAIT_CYCLES+1 cycles):
    - rom_ce_n=0, rom_oe_n=0.
    - Counter decrements each cycle.
    - On the cycle where counter==0: capture rom_data into rdata, set the granted ack for the next cycle, go to RECOVER.
  - RECOVER (1 cycle):
    - rom_ce_n=1, rom_oe_n=1, granted ack=1; go to IDLE.
- Latency: req high in IDLE at cycle 0 -> ack high at cycle WAIT_CYCLES+3. For WAIT_CYCLES=2, ack is high at cycle 5.
- Throughput: one access per WAIT_CYCLES+4 cycles under continuous requests.
- Acks are mutually exclusive and exactly one cycle wide. rdata changes only in the cycle its ack is asserted.
- rom_addr is latched at grant. Later changes to fetch_addr/data_addr do not affect the access in flight. rom_addr holds its value in IDLE.
- A requester that drops req after grant still receives its ack. The access always completes; there is no abort.
- A requester that keeps req high in the cycle after ack is treated as issuing a new request.
- Arbitration in IDLE, with only one req high: grant that requester.
- Arbitration in IDLE, with both req high: follow the policy under Optional Feature.
- Reset mid-access: rom_ce_n and rom_oe_n go to 1 immediately (asynchronously). No ack is issued. After release the controller starts in IDLE.

Optional Feature:
Macro: K12A_ROM_CTRL_ROUND_ROBIN_EN.
- Defined: when both reqs are high, grant the requester that is not the last-grant pointer. The pointer updates on every grant. Under continuous dual requests, fetch and data alternate, starting with fetch after reset.
- Undefined: fixed priority, fetch always wins and data can starve. The last-grant pointer is not implemented.

Test Plan:
- WAIT_CYCLES=2; fetch_req=1, fetch_addr=15'h0010 at cycle 0, ROM[0x0010]=8'hA5 -> rom_ce_n low cycles 1-4, rom_oe_n low cycles 2-4, fetch_ack=1 only in cycle 5, rdata=8'hA5 from cycle 5; data_ack never asserted.
- Both reqs held high, fetch_addr=15'h0001 (8'h11), data_addr=15'h7FFF (8'hEE), macro undefined -> fetch_ack every 6 cycles with rdata=8'h11; data_ack never asserted.
- Same stimulus, macro defined -> acks alternate fetch, data, fetch, ... every 6 cycles; rdata alternates 8'h11, 8'hEE.
- WAIT_CYCLES=0; data_req at cycle 0, addr 15'h1234 -> rom_oe_n low only in cycle 2, data_ack in cycle 3; busy high cycles 1-3.
- WAIT_CYCLES=2; fetch_addr changed from 15'h0010 to 15'h0020 in cycle 2 -> rom_addr stays 15'h0010 through the access; rdata is ROM[0x0010].
- reset_n=0 asynchronously during READ -> rom_ce_n=1 and rom_oe_n=1 immediately, no ack; after release and a new req, the normal cycle WAIT_CYCLES+3 latency applies.
